// File: rtl/serial_add_ctrl_if.sv
// Handshake/bus bundle for serial_add_ctrl.
// The requester uses the master modport and the adder uses the slave modport.
// Build option: SERIAL_SUB_EN adds the 'sub' request bit (subtract mode).
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_SUB_EN
    modport master (output start, a_in, b_in, cin, sub,
                    input  busy, done, sum, cout);
    modport slave  (input  start, a_in, b_in, cin, sub,
                    output busy, done, sum, cout);
`else
    modport master (output start, a_in, b_in, cin,
                    input  busy, done, sum, cout);
    modport slave  (input  start, a_in, b_in, cin,
                    output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH clocks,
// LSB first, with a start/busy/done handshake and a registered result.
// Build option: SERIAL_SUB_EN enables subtract mode (b inverted, carry-in forced to 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_a_sh, w_a_sh_next;
    logic [WIDTH-1:0] r_b_sh, w_b_sh_next;
    logic [WIDTH-1:0] r_s_sh, w_s_sh_next;
    logic             r_c, w_c_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic [WIDTH-1:0] r_sum, w_sum_next;
    logic             r_cout, w_cout_next;

    logic             w_fa_s, w_fa_c;
    logic [WIDTH-1:0] w_s_shifted;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // The single shared full-adder cell.
    assign w_fa_s = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_fa_c = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_s_one
            assign w_s_shifted = w_fa_s;
        end else begin : g_s_multi
            assign w_s_shifted = {w_fa_s, r_s_sh[WIDTH-1:1]};
        end
    endgenerate

    // Subtraction is a + ~b + 1, so only the B operand and carry-in change.
`ifdef SERIAL_SUB_EN
    assign w_b_load = bus.sub ? ~bus.b_in : bus.b_in;
    assign w_c_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_load = bus.b_in;
    assign w_c_load = bus.cin;
`endif

    // Next-state and datapath updates; every register holds unless changed.
    always_comb begin
        w_state_next = r_state;
        w_a_sh_next  = r_a_sh;
        w_b_sh_next  = r_b_sh;
        w_s_sh_next  = r_s_sh;
        w_c_next     = r_c;
        w_cnt_next   = r_cnt;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_sum_next   = r_sum;
        w_cout_next  = r_cout;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_a_sh_next  = bus.a_in;
                    w_b_sh_next  = w_b_load;
                    w_c_next     = w_c_load;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_a_sh_next = r_a_sh >> 1;
                w_b_sh_next = r_b_sh >> 1;
                w_s_sh_next = w_s_shifted;
                w_c_next    = w_fa_c;
                w_cnt_next  = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_sum_next   = w_s_shifted;
                    w_cout_next  = w_fa_c;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a_sh  <= w_a_sh_next;
            r_b_sh  <= w_b_sh_next;
            r_s_sh  <= w_s_sh_next;
            r_c     <= w_c_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_sum   <= w_sum_next;
            r_cout  <= w_cout_next;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a result scoreboard.
// Define SERIAL_SUB_EN for both RTL and bench to cover subtract mode.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic [WIDTH:0] exp_q[$];

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {cout,sum} of an add, computed with wide arithmetic.
    function automatic logic [WIDTH:0] add_model(input logic [WIDTH-1:0] a, b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Expected {cout,sum} of a subtract: cout is NOT borrow.
    function automatic logic [WIDTH:0] sub_model(input logic [WIDTH-1:0] a, b);
        logic [WIDTH-1:0] d;
        d = a - b;
        return {(a >= b), d};
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(posedge clk) begin
        logic [WIDTH:0] e;
        #1;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("done_without_op", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                $display("result sum=%0h cout=%0b expected sum=%0h cout=%0b",
                         bus.sum, bus.cout, e[WIDTH-1:0], e[WIDTH]);
                check("sum", bus.sum, e[WIDTH-1:0]);
                check("cout", bus.cout, e[WIDTH]);
            end
        end
    end

    // One operation: start pulse, then measure busy length and done latency.
    task automatic run_op(input logic [WIDTH-1:0] a, b, input logic c, input logic s,
                          input logic [WIDTH:0] exp);
        int lat;
        int busy_cycles;
        bit seen;
        exp_q.push_back(exp);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = c;
`ifdef SERIAL_SUB_EN
        bus.sub   = s;
`else
        if (s) $display("note: sub request ignored in add-only build");
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        seen = 0;
        while (!seen && lat < WIDTH + 4) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) check("early_done", bus.done, 0);
            tick();
            lat++;
            if (bus.done === 1'b1) seen = 1;
        end
        check("done_seen", seen, 1);
        check("done_latency", lat, WIDTH);
        check("busy_cycles", busy_cycles, WIDTH);
        check("busy_low_at_done", bus.busy, 0);
        tick();
        check("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        int edges;
        bit seen;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_SUB_EN
        bus.sub   = 1'b0;
`endif
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        rst = 1'b0;
        tick();

        // Basic adds, including carry-out and carry-in cases.
        run_op(8'h35, 8'h4A, 1'b0, 1'b0, add_model(8'h35, 8'h4A, 1'b0));
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, add_model(8'hFF, 8'h01, 1'b0));
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, add_model(8'hFF, 8'hFF, 1'b1));

        // start while busy must be ignored.
        exp_q.push_back(add_model(8'h10, 8'h20, 1'b0));
        done_cnt = 0;
        bus.a_in = 8'h10; bus.b_in = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.a_in = 8'hAA; bus.b_in = 8'h55; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (WIDTH + 4) tick();
        check("ignored_start_single_done", done_cnt, 1);
        check("sum_held", bus.sum, 8'h30);
        check("busy_idle_after", bus.busy, 0);

        // Back-to-back with start held high; next operands shown in the done cycle.
        done_cnt = 0;
        exp_q.push_back(add_model(8'h01, 8'h01, 1'b0));
        bus.a_in = 8'h01; bus.b_in = 8'h01; bus.start = 1'b1;
        tick();
        edges = 0;
        seen = 0;
        while (!seen && edges < 20) begin
            tick();
            edges++;
            if (bus.done === 1'b1) seen = 1;
        end
        check("b2b_first_edge", edges, 8);
        exp_q.push_back(add_model(8'h02, 8'h03, 1'b0));
        bus.a_in = 8'h02; bus.b_in = 8'h03;
        tick();
        edges++;
        bus.start = 1'b0;
        check("b2b_second_accepted", bus.busy, 1);
        seen = 0;
        while (!seen && edges < 30) begin
            tick();
            edges++;
            if (bus.done === 1'b1) seen = 1;
        end
        check("b2b_second_edge", edges, 17);
        tick();
        check("b2b_done_count", done_cnt, 2);

        // Reset mid-operation aborts with no done.
        done_cnt = 0;
        bus.a_in = 8'hC3; bus.b_in = 8'h3C; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_done", bus.done, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (WIDTH) tick();
        check("abort_no_done", done_cnt, 0);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, add_model(8'h0F, 8'h01, 1'b0));

`ifdef SERIAL_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 1'b1, sub_model(8'h10, 8'h01));
        run_op(8'h00, 8'h01, 1'b0, 1'b1, sub_model(8'h00, 8'h01));
        run_op(8'h10, 8'h01, 1'b0, 1'b0, add_model(8'h10, 8'h01, 1'b0));
`else
        if (sub_model(8'h10, 8'h01) == 9'h10F) $display("sub model only used with SERIAL_SUB_EN");
`endif

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
